// File: rtl/boot_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : boot_run_sequencer
// Purpose  : Takes the SoC from power-on to end-of-computation: core reset hold,
//            boot-address write, load wait, fetch enable, EOC watch and the
//            return-code read-back over a req/gnt register bus.
// Option   : define BOOT_SEQ_WATCHDOG_EN to add the RUN watchdog / TIMEOUT state.
// Revision : 1.0 - initial release
// ============================================================================
module boot_run_sequencer #(
    parameter logic [31:0] RST_HOLD_CYC  = 32'd13,
    parameter logic [31:0] SETTLE_CYC    = 32'd13,
    parameter logic [31:0] FETCH_DLY_CYC = 32'd5,
    parameter logic [31:0] BOOT_ADDR_REG = 32'h1A10_7008,
    parameter logic [31:0] BOOT_ADDR     = 32'h0000_0000,
    parameter logic [31:0] STATUS_ADDR   = 32'h1A10_7014,
    parameter logic [31:0] WDOG_CYC      = 32'd16777216
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  load_mode_i,
    input  logic        load_done_i,
    input  logic        eoc_i,
    output logic        core_rst_n_o,
    output logic        fetch_enable_o,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    output logic        done_o,
    output logic        pass_o,
    output logic [31:0] exit_status_o,
    output logic        timeout_o
);

    typedef enum logic [3:0] {
        ST_RST_HOLD  = 4'd0,
        ST_SETTLE    = 4'd1,
        ST_BOOT_WR   = 4'd2,
        ST_LOAD_WAIT = 4'd3,
        ST_FETCH_DLY = 4'd4,
        ST_RUN       = 4'd5,
        ST_RD_STATUS = 4'd6,
        ST_DONE      = 4'd7
`ifdef BOOT_SEQ_WATCHDOG_EN
        , ST_TIMEOUT = 4'd8
`endif
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cnt;
    logic        core_rst_n;
    logic        fetch_en;
    logic        load_seen;
    logic        rd_granted;
    logic [1:0]  load_mode;
    logic [31:0] exit_status;
    logic [1:0]  eoc_sync;
    logic        eoc_s;
    logic        standalone;

    // A limit of 0 still occupies the state for one cycle.
    function automatic logic cyc_done(input logic [31:0] limit, input logic [31:0] count);
        return (limit == 32'd0) || (count >= (limit - 32'd1));
    endfunction

    assign eoc_s      = eoc_sync[1];
    assign standalone = (load_mode == 2'd2) || (load_mode == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RST_HOLD;
            cnt         <= 32'd0;
            core_rst_n  <= 1'b0;
            fetch_en    <= 1'b0;
            load_seen   <= 1'b0;
            rd_granted  <= 1'b0;
            load_mode   <= 2'd0;
            exit_status <= 32'd0;
            eoc_sync    <= 2'b00;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? 32'd0 : cnt + 32'd1;
            if ((state == ST_RST_HOLD) && (state_nxt != ST_RST_HOLD)) begin
                core_rst_n <= 1'b1;
                load_mode  <= load_mode_i;
            end
            if (core_rst_n && load_done_i) begin
                load_seen <= 1'b1;
            end
            if ((state == ST_FETCH_DLY) && (state_nxt == ST_RUN)) begin
                fetch_en <= 1'b1;
            end
            // Synchroniser is held clear outside RUN so an early EOC is seen as a level after entry.
            eoc_sync <= (state == ST_RUN) ? {eoc_sync[0], eoc_i} : 2'b00;
            if ((state == ST_RD_STATUS) && gnt_i) begin
                rd_granted <= 1'b1;
            end
            if ((state == ST_RD_STATUS) && (state_nxt == ST_DONE)) begin
                exit_status <= rdata_i;
            end
`ifdef BOOT_SEQ_WATCHDOG_EN
            if ((state == ST_RUN) && (state_nxt == ST_TIMEOUT)) begin
                fetch_en    <= 1'b0;
                exit_status <= 32'hFFFF_FFFF;
            end
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        req_o     = 1'b0;
        we_o      = 1'b0;
        addr_o    = 32'd0;
        wdata_o   = 32'd0;
        case (state)
            ST_RST_HOLD: begin
                if (cyc_done(RST_HOLD_CYC, cnt)) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cyc_done(SETTLE_CYC, cnt)) state_nxt = standalone ? ST_FETCH_DLY : ST_BOOT_WR;
            end
            ST_BOOT_WR: begin
                req_o   = 1'b1;
                we_o    = 1'b1;
                addr_o  = BOOT_ADDR_REG;
                wdata_o = BOOT_ADDR;
                if (gnt_i) state_nxt = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                if (load_seen || load_done_i) state_nxt = ST_FETCH_DLY;
            end
            ST_FETCH_DLY: begin
                if (cyc_done(FETCH_DLY_CYC, cnt)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (eoc_s) begin
                    state_nxt = ST_RD_STATUS;
                end
`ifdef BOOT_SEQ_WATCHDOG_EN
                else if (cyc_done(WDOG_CYC, cnt)) begin
                    state_nxt = ST_TIMEOUT;
                end
`endif
            end
            ST_RD_STATUS: begin
                req_o  = !rd_granted;
                addr_o = STATUS_ADDR;
                // Read data may return in the same cycle as the grant.
                if ((rd_granted || gnt_i) && rvalid_i) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
`ifdef BOOT_SEQ_WATCHDOG_EN
            ST_TIMEOUT: begin
                state_nxt = ST_TIMEOUT;
            end
`endif
            default: begin
                state_nxt = ST_RST_HOLD;
            end
        endcase
    end

    assign core_rst_n_o   = core_rst_n;
    assign fetch_enable_o = fetch_en;
    assign exit_status_o  = exit_status;

`ifdef BOOT_SEQ_WATCHDOG_EN
    assign done_o    = (state == ST_DONE) || (state == ST_TIMEOUT);
    assign timeout_o = (state == ST_TIMEOUT);
`else
    logic [31:0] unused_wdog;
    assign unused_wdog = WDOG_CYC;
    assign done_o      = (state == ST_DONE);
    assign timeout_o   = 1'b0;
`endif
    assign pass_o = (state == ST_DONE) && (exit_status == 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_boot_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_run_sequencer
// Purpose  : Directed self-checking bench for boot_run_sequencer with a bus
//            scoreboard; define BOOT_SEQ_WATCHDOG_EN to exercise the watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_run_sequencer;

    localparam int          RH       = 13;
    localparam int          SC       = 13;
    localparam int          FD       = 5;
    localparam logic [31:0] BOOT_REG = 32'h1A10_7008;
    localparam logic [31:0] STAT_REG = 32'h1A10_7014;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  load_mode_i;
    logic        load_done_i;
    logic        eoc_i;
    logic        core_rst_n_o, fetch_enable_o, req_o, we_o;
    logic [31:0] addr_o, wdata_o;
    logic        gnt_i, rvalid_i;
    logic [31:0] rdata_i;
    logic        done_o, pass_o, timeout_o;
    logic [31:0] exit_status_o;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          gnt_delay = 0;
    logic [31:0] rd_value = 32'd0;

    boot_run_sequencer #(.WDOG_CYC(32'd100)) dut (
        .clk(clk), .rst(rst), .load_mode_i(load_mode_i), .load_done_i(load_done_i),
        .eoc_i(eoc_i), .core_rst_n_o(core_rst_n_o), .fetch_enable_o(fetch_enable_o),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .done_o(done_o), .pass_o(pass_o), .exit_status_o(exit_status_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return core_rst_n_o;
            1:       return req_o;
            2:       return fetch_enable_o;
            3:       return done_o;
            4:       return timeout_o;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic val, input int limit, input string tag);
        for (int i = 0; i < limit && sig(which) !== val; i++) @(negedge clk);
        check(tag, {31'd0, sig(which)}, {31'd0, val});
    endtask

    task automatic push_wr();
        txn_t t;
        t.we = 1'b1; t.addr = BOOT_REG; t.wdata = 32'h0000_0000;
        exp_q.push_back(t);
    endtask

    task automatic push_rd();
        txn_t t;
        t.we = 1'b0; t.addr = STAT_REG; t.wdata = 32'h0;
        exp_q.push_back(t);
    endtask

    task automatic pulse_load_at(input int c);
        while (cyc < c) @(negedge clk);
        load_done_i = 1'b1;
        @(negedge clk);
        load_done_i = 1'b0;
    endtask

    task automatic do_reset(input logic [1:0] mode);
        @(negedge clk);
        rst = 1'b1;
        load_mode_i = mode;
        load_done_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctrl_outs", {25'd0, core_rst_n_o, fetch_enable_o, req_o, we_o, done_o, pass_o, timeout_o}, 32'd0);
        check("reset_exit_status", exit_status_o, 32'd0);
        check("reset_addr", addr_o, 32'd0);
        rst = 1'b0;
    endtask

    // Bus responder: grants after gnt_delay cycles of request, read data with the grant.
    initial begin
        int wait_cnt = 0;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = rd_value;
            if (req_o && !rst) begin
                if (wait_cnt >= gnt_delay) begin
                    gnt_i = 1'b1;
                    rvalid_i = !we_o;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard: every accepted transfer must match the next expected one.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && req_o && gnt_i) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL bus_unexpected: observed addr %0h we %0b expected none", addr_o, we_o);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("bus_we", {31'd0, we_o}, {31'd0, e.we});
                    check("bus_addr", addr_o, e.addr);
                    if (e.we) check("bus_wdata", wdata_o, e.wdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int   lw;
        int   r;
        int   pc;
        logic saw;
        rst = 1'b1; load_mode_i = 2'd0; load_done_i = 1'b0; eoc_i = 1'b0;

        // 1: PRELOAD, load pulse in SETTLE, grant two cycles late, pass.
        gnt_delay = 2; rd_value = 32'd0;
        push_wr(); push_rd();
        do_reset(2'd0);
        wait_sig(0, 1'b1, 40, "t1_core_release");
        check("t1_release_cycle", cyc, RH);
        pulse_load_at(RH + 3);
        wait_sig(1, 1'b1, 40, "t1_write_req");
        check("t1_first_access_cycle", cyc, RH + SC);
        wait_sig(1, 1'b0, 20, "t1_write_accepted");
        lw = cyc;
        wait_sig(2, 1'b1, 20, "t1_fetch");
        check("t1_fetch_cycle", cyc, lw + FD + 1);
        eoc_i = 1'b1;
        wait_sig(3, 1'b1, 30, "t1_done");
        check("t1_exit_status", exit_status_o, 32'd0);
        check("t1_pass", {31'd0, pass_o}, 32'd1);
        eoc_i = 1'b0;
        pulse_load_at(cyc);
        repeat (5) @(negedge clk);
        check("t1_done_sticky", {29'd0, done_o, pass_o, fetch_enable_o}, 32'd7);
        check("t1_scoreboard_empty", exp_q.size(), 0);

        // 2: STANDALONE and reserved mode: no bus access before RUN.
        for (int m = 2; m <= 3; m++) begin
            gnt_delay = 0;
            do_reset(m[1:0]);
            saw = 1'b0;
            for (int i = 0; i < 80 && !fetch_enable_o; i++) begin
                @(negedge clk);
                if (req_o) saw = 1'b1;
            end
            check("t2_fetch_cycle", cyc, RH + SC + FD);
            check("t2_no_req_before_run", {31'd0, saw}, 32'd0);
        end
        rd_value = 32'd0;
        push_rd();
        eoc_i = 1'b1;
        wait_sig(3, 1'b1, 30, "t2_done");
        check("t2_pass", {31'd0, pass_o}, 32'd1);
        check("t2_scoreboard_empty", exp_q.size(), 0);
        eoc_i = 1'b0;

        // 3: pulses in RST_HOLD and SETTLE; only the SETTLE pulse counts.
        gnt_delay = 0;
        push_wr();
        do_reset(2'd0);
        pulse_load_at(5);
        pulse_load_at(RH + 5);
        wait_sig(1, 1'b1, 40, "t3_write_req");
        wait_sig(1, 1'b0, 10, "t3_write_accepted");
        lw = cyc;
        wait_sig(2, 1'b1, 20, "t3_fetch");
        check("t3_fetch_cycle", cyc, lw + FD + 1);

        // 3b: pulse only during RST_HOLD must leave LOAD_WAIT pending.
        push_wr();
        do_reset(2'd0);
        pulse_load_at(5);
        wait_sig(1, 1'b1, 40, "t3b_write_req");
        wait_sig(1, 1'b0, 10, "t3b_write_accepted");
        repeat (40) @(negedge clk);
        check("t3b_held_in_load_wait", {31'd0, fetch_enable_o}, 32'd0);
        pc = cyc;
        pulse_load_at(pc);
        wait_sig(2, 1'b1, 20, "t3b_fetch");
        check("t3b_fetch_delay_ok", {31'd0, (cyc - pc >= FD + 1) && (cyc - pc <= FD + 2)}, 32'd1);
        check("t3b_scoreboard_empty", exp_q.size(), 0);

        // 4: EOC high from time 0, non-zero return code.
        eoc_i = 1'b1; rd_value = 32'h0000_0003; gnt_delay = 0;
        push_wr(); push_rd();
        do_reset(2'd0);
        pulse_load_at(RH + 2);
        wait_sig(2, 1'b1, 60, "t4_fetch");
        r = cyc;
        wait_sig(1, 1'b1, 10, "t4_read_req");
        check("t4_read_we", {31'd0, we_o}, 32'd0);
        check("t4_eoc_latency_ok", {31'd0, (cyc - r >= 2) && (cyc - r <= 3)}, 32'd1);
        wait_sig(3, 1'b1, 10, "t4_done");
        check("t4_exit_status", exit_status_o, 32'd3);
        check("t4_pass", {31'd0, pass_o}, 32'd0);
        check("t4_scoreboard_empty", exp_q.size(), 0);
        eoc_i = 1'b0;

        // 5: reset while the boot write waits for a grant, then a full restart.
        gnt_delay = 1000;
        do_reset(2'd0);
        wait_sig(1, 1'b1, 40, "t5_write_req");
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("t5_async_core_rst", {31'd0, core_rst_n_o}, 32'd0);
        check("t5_async_req_drop", {31'd0, req_o}, 32'd0);
        gnt_delay = 0; rd_value = 32'd0;
        push_wr(); push_rd();
        do_reset(2'd0);
        wait_sig(0, 1'b1, 40, "t5_core_release");
        check("t5_release_cycle", cyc, RH);
        pulse_load_at(RH + 1);
        wait_sig(2, 1'b1, 60, "t5_fetch");
        eoc_i = 1'b1;
        wait_sig(3, 1'b1, 20, "t5_done");
        check("t5_pass", {31'd0, pass_o}, 32'd1);
        check("t5_scoreboard_empty", exp_q.size(), 0);
        eoc_i = 1'b0;

        // 6: RUN with no EOC.
        do_reset(2'd2);
        wait_sig(2, 1'b1, 60, "t6_fetch");
        r = cyc;
`ifdef BOOT_SEQ_WATCHDOG_EN
        wait_sig(4, 1'b1, 120, "t6_timeout");
        check("t6_timeout_cycle", cyc, r + 100);
        check("t6_exit_status", exit_status_o, 32'hFFFF_FFFF);
        check("t6_flags", {29'd0, done_o, pass_o, fetch_enable_o}, 32'd4);
`else
        repeat (150) @(negedge clk);
        check("t6_no_timeout", {29'd0, timeout_o, done_o, fetch_enable_o}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
